// File: rtl/botoeira_pedestre.sv
// Pedestrian push-button front end: synchronizes and debounces the button and raises one crossing request per press.
// Optional served-request counter (num_pedidos) is enabled by defining BOTOEIRA_CONTADOR_EN.

module botoeira_pedestre #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       botao,
  input  logic       pedestre_2_verde,
  output logic       pedestre,
  output logic       aguarde
`ifdef BOTOEIRA_CONTADOR_EN
  ,
  output logic [7:0] num_pedidos
`endif
);

  // state    | meaning
  // IDLE     | waiting for the synchronized button to go high
  // DEBOUNCE | counting consecutive high samples
  // REQUEST  | request raised, waiting for the walk lamp
  // SERVING  | walk lamp on
  // HOLDOFF  | fixed quiet time after the crossing, button ignored
  // RELEASE  | waiting for the button to be let go
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    REQUEST  = 3'd2,
    SERVING  = 3'd3,
    HOLDOFF  = 3'd4,
    RELEASE  = 3'd5
  } state_t;

  localparam logic [7:0] DEB_TC  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] HOLD_TC = 8'(HOLDOFF_CYCLES - 1);

  state_t     state, state_nxt;
  logic       botao_m, botao_s;
  logic [7:0] deb_cnt, deb_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       served;

  always_ff @(posedge clk) begin
    if (reset) begin
      botao_m <= 1'b0;
      botao_s <= 1'b0;
    end else begin
      botao_m <= botao;
      botao_s <= botao_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      deb_cnt  <= 8'd0;
      hold_cnt <= 8'd0;
      pedestre <= 1'b0;
      aguarde  <= 1'b0;
    end else begin
      state    <= state_nxt;
      deb_cnt  <= deb_nxt;
      hold_cnt <= hold_nxt;
      pedestre <= (state_nxt == REQUEST);
      aguarde  <= (state_nxt == REQUEST);
    end
  end

  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    hold_nxt  = hold_cnt;
    served    = 1'b0;
    case (state)
      IDLE: begin
        if (botao_s) begin
          state_nxt = DEBOUNCE;
          deb_nxt   = 8'd1;
        end else begin
          deb_nxt = 8'd0;
        end
      end
      DEBOUNCE: begin
        if (!botao_s) begin
          state_nxt = IDLE;
          deb_nxt   = 8'd0;
        end else if (deb_cnt >= DEB_TC) begin
          deb_nxt = 8'd0;
          // Lamp already green: the pedestrian is served without a request.
          if (pedestre_2_verde) begin
            state_nxt = SERVING;
            served    = 1'b1;
          end else begin
            state_nxt = REQUEST;
          end
        end else begin
          deb_nxt = deb_cnt + 8'd1;
        end
      end
      REQUEST: begin
        if (pedestre_2_verde) begin
          state_nxt = SERVING;
          served    = 1'b1;
        end
      end
      SERVING: begin
        if (!pedestre_2_verde) begin
          state_nxt = HOLDOFF;
          hold_nxt  = 8'd0;
        end
      end
      HOLDOFF: begin
        if (hold_cnt >= HOLD_TC) begin
          state_nxt = RELEASE;
          hold_nxt  = 8'd0;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      RELEASE: begin
        // A held button must be released before another request can start.
        if (!botao_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        deb_nxt   = 8'd0;
        hold_nxt  = 8'd0;
      end
    endcase
  end

`ifdef BOTOEIRA_CONTADOR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      num_pedidos <= 8'd0;
    end else if (served && (num_pedidos != 8'hFF)) begin
      num_pedidos <= num_pedidos + 8'd1;
    end
  end
`else
  logic unused_served;
  assign unused_served = served;
`endif

endmodule

// File: tb/tb_botoeira_pedestre.sv
// Bench for botoeira_pedestre: directed scenarios plus random stimulus against an event-level model.
module tb_botoeira_pedestre;
  localparam int DEB  = 4;
  localparam int HOLD = 20;

  logic clk = 1'b0;
  logic reset, botao, pedestre_2_verde;
  logic pedestre, aguarde;
`ifdef BOTOEIRA_CONTADOR_EN
  logic [7:0] num_pedidos;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  botoeira_pedestre #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .botao(botao),
    .pedestre_2_verde(pedestre_2_verde),
    .pedestre(pedestre),
    .aguarde(aguarde)
`ifdef BOTOEIRA_CONTADOR_EN
    ,
    .num_pedidos(num_pedidos)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_num(input string name, input int exp);
`ifdef BOTOEIRA_CONTADOR_EN
    chk(name, {24'd0, num_pedidos}, exp);
`endif
  endtask

  // Model: phases of a pedestrian's interaction, with a run length of consecutive button samples.
  localparam int P_ARMED = 0, P_WAIT_ACK = 1, P_WALK = 2, P_COOL = 3, P_LATCH = 4;
  int   m_phase, m_run, m_left;
  logic [1:0] m_sync;
  logic m_bs, m_ped;
  logic m_valid = 1'b0;
`ifdef BOTOEIRA_CONTADOR_EN
  int   m_num;
`endif

  always @(posedge clk) begin
    m_bs = m_sync[1];
    if (reset) begin
      m_valid = 1'b1;
      m_phase = P_ARMED;
      m_run   = 0;
      m_left  = 0;
      m_sync  = 2'b00;
`ifdef BOTOEIRA_CONTADOR_EN
      m_num   = 0;
`endif
    end else if (m_valid) begin
      m_sync = {m_sync[0], botao};
      if (m_phase == P_ARMED) begin
        // A press is accepted on the sample after DEB consecutive highs.
        m_run = m_bs ? m_run + 1 : 0;
        if (m_run == DEB + 1) begin
          m_run = 0;
          if (pedestre_2_verde) begin
            m_phase = P_WALK;
`ifdef BOTOEIRA_CONTADOR_EN
            if (m_num < 255) m_num++;
`endif
          end else begin
            m_phase = P_WAIT_ACK;
          end
        end
      end else if (m_phase == P_WAIT_ACK) begin
        if (pedestre_2_verde) begin
          m_phase = P_WALK;
`ifdef BOTOEIRA_CONTADOR_EN
          if (m_num < 255) m_num++;
`endif
        end
      end else if (m_phase == P_WALK) begin
        if (!pedestre_2_verde) begin
          m_phase = P_COOL;
          m_left  = HOLD;
        end
      end else if (m_phase == P_COOL) begin
        m_left--;
        if (m_left == 0) m_phase = P_LATCH;
      end else begin
        if (!m_bs) m_phase = P_ARMED;
      end
    end
    m_ped = (m_phase == P_WAIT_ACK);
  end

  logic ped_prev = 1'b0;
  int   ped_rises = 0;

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      chk("pedestre_vs_model", {31'd0, pedestre}, {31'd0, m_ped});
      chk("aguarde_vs_model", {31'd0, aguarde}, {31'd0, m_ped});
`ifdef BOTOEIRA_CONTADOR_EN
      chk("num_pedidos_vs_model", {24'd0, num_pedidos}, m_num);
`endif
    end
    if (pedestre === 1'b1 && ped_prev === 1'b0) ped_rises++;
    ped_prev = pedestre;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    botao = 1'b0;
    pedestre_2_verde = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_pedestre", {31'd0, pedestre}, 0);
    chk("reset_aguarde", {31'd0, aguarde}, 0);
    chk_num("reset_num", 0);
  endtask

  // Raise botao and count edges until pedestre rises; -1 on timeout.
  task automatic press_lat(output int lat);
    lat = -1;
    @(negedge clk);
    botao = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (pedestre === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic ack_and_finish();
    repeat (5) @(negedge clk);
    botao = 1'b0;
    pedestre_2_verde = 1'b1;
    repeat (10) @(negedge clk);
    pedestre_2_verde = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  int lat, r0;

  initial begin
    reset = 1'b1;
    botao = 1'b0;
    pedestre_2_verde = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Clean press
    do_reset();
    press_lat(lat);
    chk("clean_latency", lat, DEB + 3);
    repeat (4) @(negedge clk);
    botao = 1'b0;
    @(negedge clk);
    chk("clean_still_requesting", {31'd0, pedestre}, 1);
    pedestre_2_verde = 1'b1;
    @(posedge clk);
    #1;
    chk("clean_ped_low_after_ack", {31'd0, pedestre}, 0);
    chk("clean_aguarde_low_after_ack", {31'd0, aguarde}, 0);
    chk_num("clean_num", 1);
    repeat (10) @(negedge clk);
    pedestre_2_verde = 1'b0;
    repeat (30) @(negedge clk);

    // Bounce
    do_reset();
    r0 = ped_rises;
    botao = 1'b1; @(negedge clk);
    botao = 1'b1; @(negedge clk);
    botao = 1'b0; @(negedge clk);
    botao = 1'b1; @(negedge clk);
    botao = 1'b0;
    repeat (20) @(negedge clk);
    chk("bounce_no_request", ped_rises - r0, 0);
    press_lat(lat);
    chk("bounce_then_clean_latency", lat, DEB + 3);
    ack_and_finish();

    // Stuck button
    do_reset();
    r0 = ped_rises;
    press_lat(lat);
    repeat (5) @(negedge clk);
    pedestre_2_verde = 1'b1;
    repeat (20) @(negedge clk);
    pedestre_2_verde = 1'b0;
    repeat (170) @(negedge clk);
    botao = 1'b0;
    repeat (30) @(negedge clk);
    chk("stuck_one_request", ped_rises - r0, 1);
    chk_num("stuck_num", 1);

    // Press during holdoff
    do_reset();
    press_lat(lat);
    repeat (5) @(negedge clk);
    botao = 1'b0;
    pedestre_2_verde = 1'b1;
    repeat (10) @(negedge clk);
    pedestre_2_verde = 1'b0;
    repeat (5) @(negedge clk);
    r0 = ped_rises;
    botao = 1'b1;
    repeat (10) @(negedge clk);
    botao = 1'b0;
    repeat (19) @(negedge clk);
    chk("holdoff_press_ignored", ped_rises - r0, 0);
    press_lat(lat);
    chk("after_holdoff_latency", lat, DEB + 3);
    ack_and_finish();

    // Walk already green
    do_reset();
    pedestre_2_verde = 1'b1;
    r0 = ped_rises;
    botao = 1'b1;
    repeat (10) @(negedge clk);
    botao = 1'b0;
    repeat (5) @(negedge clk);
    chk("green_no_request", ped_rises - r0, 0);
    chk_num("green_num", 1);
    pedestre_2_verde = 1'b0;
    repeat (30) @(negedge clk);

    // Reset mid-request
    do_reset();
    press_lat(lat);
    @(negedge clk);
    reset = 1'b1;
    botao = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_pedestre", {31'd0, pedestre}, 0);
    chk("midreset_aguarde", {31'd0, aguarde}, 0);
    chk_num("midreset_num", 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    press_lat(lat);
    chk("midreset_fresh_latency", lat, DEB + 3);
    ack_and_finish();

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) botao = ~botao;
      if ($urandom_range(0, 15) == 0) pedestre_2_verde = ~pedestre_2_verde;
      reset = ($urandom_range(0, 799) == 0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
